// File: rtl/tx_link_scheduler.sv
// Byte-slot framing and round-robin arbitration for a single 8-bit TX lane:
// STP/payload/END packets from two requesters, logical idle, and periodic SKP ordered sets.
module tx_link_scheduler #(
    parameter int SKP_INTERVAL = 1180,
    parameter int CNT_W        = 11,
    parameter int SKP_LEN      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       byte_tick,
    input  logic       req_a,
    input  logic [7:0] len_a,
    input  logic [7:0] data_a,
    input  logic       req_b,
    input  logic [7:0] len_b,
    input  logic [7:0] data_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       rd_a,
    output logic       rd_b,
    output logic [7:0] dataOut,
    output logic       kOut,
    output logic [1:0] dataS,
    output logic       busy
);

    localparam logic [7:0] SYM_IDL = 8'h00;
    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STP     = 3'd1,
        S_DATA    = 3'd2,
        S_END     = 3'd3,
        S_SKP_COM = 3'd4,
        S_SKP     = 3'd5
    } state_t;

    state_t           state_r, state_nx_s;
    logic [7:0]       rem_r, rem_nx_s;
    logic [CNT_W-1:0] skp_cnt_r, skp_cnt_nx_s;
    logic             last_b_r, last_b_nx_s;
    logic             gnt_a_r, gnt_a_nx_s, gnt_b_r, gnt_b_nx_s;
    logic [7:0]       data_r, data_nx_s;
    logic             k_r, k_nx_s;
    logic             busy_r;
    logic             rd_a_s, rd_b_s;
    logic             tick_s, skp_pend_s, pick_b_s;

    assign tick_s     = enb & byte_tick;
    assign skp_pend_s = (skp_cnt_r == CNT_W'(SKP_INTERVAL));
    // B wins only when it is alone or when A was the last one served
    assign pick_b_s   = req_b & (~req_a | ~last_b_r);

    // Next-state, next-symbol and pop-strobe decode; rem_r doubles as payload and SKP countdown
    always_comb begin
        state_nx_s  = state_r;
        rem_nx_s    = rem_r;
        last_b_nx_s = last_b_r;
        gnt_a_nx_s  = gnt_a_r;
        gnt_b_nx_s  = gnt_b_r;
        data_nx_s   = SYM_IDL;
        k_nx_s      = 1'b0;
        rd_a_s      = 1'b0;
        rd_b_s      = 1'b0;
        case (state_r)
            S_IDLE, S_END: begin
                gnt_a_nx_s = 1'b0;
                gnt_b_nx_s = 1'b0;
                if (skp_pend_s) begin
                    state_nx_s = S_SKP_COM;
                    data_nx_s  = SYM_COM;
                    k_nx_s     = 1'b1;
                    rem_nx_s   = 8'(SKP_LEN);
                end else if (req_a || req_b) begin
                    state_nx_s  = S_STP;
                    data_nx_s   = SYM_STP;
                    k_nx_s      = 1'b1;
                    gnt_a_nx_s  = ~pick_b_s;
                    gnt_b_nx_s  = pick_b_s;
                    last_b_nx_s = pick_b_s;
                    rem_nx_s    = pick_b_s ? len_b : len_a;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_STP, S_DATA: begin
                if (rem_r != 8'd0) begin
                    state_nx_s = S_DATA;
                    data_nx_s  = gnt_b_r ? data_b : data_a;
                    rem_nx_s   = rem_r - 8'd1;
                    rd_a_s     = tick_s & gnt_a_r;
                    rd_b_s     = tick_s & gnt_b_r;
                end else begin
                    state_nx_s = S_END;
                    data_nx_s  = SYM_END;
                    k_nx_s     = 1'b1;
                end
            end
            S_SKP_COM, S_SKP: begin
                if (rem_r != 8'd0) begin
                    state_nx_s = S_SKP;
                    data_nx_s  = SYM_SKP;
                    k_nx_s     = 1'b1;
                    rem_nx_s   = rem_r - 8'd1;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
                gnt_a_nx_s = 1'b0;
                gnt_b_nx_s = 1'b0;
            end
        endcase
        if (state_nx_s == S_SKP_COM) begin
            skp_cnt_nx_s = {CNT_W{1'b0}};
        end else if (!skp_pend_s) begin
            skp_cnt_nx_s = skp_cnt_r + CNT_W'(1);
        end else begin
            skp_cnt_nx_s = skp_cnt_r;
        end
    end

    // State and registered outputs advance only on an enabled byte slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            rem_r     <= 8'd0;
            skp_cnt_r <= {CNT_W{1'b0}};
            last_b_r  <= 1'b1;
            gnt_a_r   <= 1'b0;
            gnt_b_r   <= 1'b0;
            data_r    <= SYM_IDL;
            k_r       <= 1'b0;
            busy_r    <= 1'b0;
        end else if (tick_s) begin
            state_r   <= state_nx_s;
            rem_r     <= rem_nx_s;
            skp_cnt_r <= skp_cnt_nx_s;
            last_b_r  <= last_b_nx_s;
            gnt_a_r   <= gnt_a_nx_s;
            gnt_b_r   <= gnt_b_nx_s;
            data_r    <= data_nx_s;
            k_r       <= k_nx_s;
            busy_r    <= (state_nx_s != S_IDLE);
        end
    end

    assign gnt_a   = gnt_a_r;
    assign gnt_b   = gnt_b_r;
    assign rd_a    = rd_a_s;
    assign rd_b    = rd_b_s;
    assign dataOut = data_r;
    assign kOut    = k_r;
    assign dataS   = 2'b00;
    assign busy    = busy_r;

endmodule
